trap_sequencer: RTL and testbench



---
 rtl/trap_sequencer_pkg.sv | 47 ++++
 rtl/trap_priority_encoder.sv | 38 +++
 rtl/trap_sequencer.sv | 144 ++++++++++++++
 tb/tb_trap_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg: CSR addresses, cause codes, mstatus/mie bit positions, FSM encoding
package trap_sequencer_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL = 12'h343;
    localparam logic [3:0] CAUSE_EXT_IRQ = 4'd11;
    localparam logic [3:0] CAUSE_SW_IRQ = 4'd3;
    localparam logic [3:0] CAUSE_TMR_IRQ = 4'd7;
    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK = 4'd3;
    localparam logic [3:0] CAUSE_ECALL = 4'd11;
    localparam logic [3:0] CAUSE_LOAD_MIS = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MIS = 4'd6;
    localparam int MSTATUS_MIE = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP = 11;
    localparam int MIE_MSIE = 3;
    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;
    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MTVAL,
        W_MSTATUS,
        TRAP_REDIR,
        RET_MSTATUS,
        RET_REDIR
    } state_t;
    function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MSTATUS_MPIE] = m[MSTATUS_MIE];
        r[MSTATUS_MIE] = 1'b0;
        r[MSTATUS_MPP+:2] = 2'b11;
        return r;
    endfunction
    function automatic logic [31:0] ret_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MSTATUS_MIE] = m[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP+:2] = 2'b11;
        return r;
    endfunction
endpackage

// File: rtl/trap_priority_encoder.sv
// trap_priority_encoder: picks the highest-priority pending trap and its cause code
module trap_priority_encoder
    import trap_sequencer_pkg::*;
(
    input  logic        ext_irq_i,
    input  logic        sw_irq_i,
    input  logic        tmr_irq_i,
    input  logic        global_ie_i,
    input  logic [31:0] mie_i,
    input  logic        illegal_i,
    input  logic        ebreak_i,
    input  logic        ecall_i,
    input  logic        load_mis_i,
    input  logic        store_mis_i,
    output logic        valid_o,
    output logic        is_interrupt_o,
    output logic [3:0]  cause_o
);
    logic ext, sw, tmr;
    logic unused_mie;
    assign unused_mie = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};
    // interrupts need both the global enable and their own enable; exceptions follow in fixed order
    always_comb begin
        ext = ext_irq_i & global_ie_i & mie_i[MIE_MEIE];
        sw = sw_irq_i & global_ie_i & mie_i[MIE_MSIE];
        tmr = tmr_irq_i & global_ie_i & mie_i[MIE_MTIE];
        is_interrupt_o = ext | sw | tmr;
        valid_o = is_interrupt_o | illegal_i | ebreak_i | ecall_i | load_mis_i | store_mis_i;
        cause_o = ext ? CAUSE_EXT_IRQ :
                  sw ? CAUSE_SW_IRQ :
                  tmr ? CAUSE_TMR_IRQ :
                  illegal_i ? CAUSE_ILLEGAL :
                  ebreak_i ? CAUSE_EBREAK :
                  ecall_i ? CAUSE_ECALL :
                  load_mis_i ? CAUSE_LOAD_MIS :
                  store_mis_i ? CAUSE_STORE_MIS : 4'd0;
    end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: serialises trap-entry and mret CSR updates, then issues the redirect pulse
module trap_sequencer
    import trap_sequencer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_external_interrupt,
    input  logic        i_software_interrupt,
    input  logic        i_timer_interrupt,
    input  logic [31:0] i_mie,
    input  logic [31:0] i_mstatus,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    input  logic        i_is_inst_illegal,
    input  logic        i_is_ebreak,
    input  logic        i_is_ecall,
    input  logic        i_load_misaligned,
    input  logic        i_store_misaligned,
    input  logic        i_is_mret,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_y,
    input  logic        i_stall,
    input  logic        writeback_change_pc,
    output logic        o_csr_we,
    output logic [11:0] o_csr_waddr,
    output logic [31:0] o_csr_wdata,
    output logic [31:0] o_trap_address,
    output logic [31:0] o_return_address,
    output logic        o_go_to_trap_q,
    output logic        o_return_from_trap_q,
    output logic        o_busy
);
    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, tval_q, tval_d;
    logic [3:0] cause_q, cause_d, trap_cause;
    logic irq_q, irq_d, trap_valid, trap_irq, accept;

    trap_priority_encoder u_prio (
        .ext_irq_i(i_external_interrupt),
        .sw_irq_i(i_software_interrupt),
        .tmr_irq_i(i_timer_interrupt),
        .global_ie_i(i_mstatus[MSTATUS_MIE]),
        .mie_i(i_mie),
        .illegal_i(i_is_inst_illegal),
        .ebreak_i(i_is_ebreak),
        .ecall_i(i_is_ecall),
        .load_mis_i(i_load_misaligned),
        .store_mis_i(i_store_misaligned),
        .valid_o(trap_valid),
        .is_interrupt_o(trap_irq),
        .cause_o(trap_cause)
    );

    // state and trap context registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            pc_q <= '0;
            cause_q <= '0;
            irq_q <= 1'b0;
            tval_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            cause_q <= cause_d;
            irq_q <= irq_d;
            tval_q <= tval_d;
        end
    end

    // accept events only when idle and not overridden; otherwise walk the sequence unless stalled
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        cause_d = cause_q;
        irq_d = irq_q;
        tval_d = tval_q;
        accept = state_q == IDLE && !i_stall && !writeback_change_pc;
        if (accept && trap_valid) begin
            state_d = W_MEPC;
            pc_d = i_pc;
            cause_d = trap_cause;
            irq_d = trap_irq;
            tval_d = (!trap_irq && (trap_cause == CAUSE_LOAD_MIS || trap_cause == CAUSE_STORE_MIS)) ? i_y : 32'd0;
        end else if (accept && i_is_mret) begin
            state_d = RET_MSTATUS;
        end else if (state_q != IDLE && !i_stall) begin
            case (state_q)
                W_MEPC: state_d = W_MCAUSE;
                W_MCAUSE: state_d = W_MTVAL;
                W_MTVAL: state_d = W_MSTATUS;
                W_MSTATUS: state_d = TRAP_REDIR;
                RET_MSTATUS: state_d = RET_REDIR;
                default: state_d = IDLE;
            endcase
        end
    end

    // one CSR write or redirect pulse per active state; silent while stalled or in reset
    always_comb begin
        o_csr_we = 1'b0;
        o_csr_waddr = '0;
        o_csr_wdata = '0;
        o_go_to_trap_q = 1'b0;
        o_return_from_trap_q = 1'b0;
        o_busy = !i_rst && state_q != IDLE;
        if (!i_rst && !i_stall) begin
            case (state_q)
                W_MEPC: begin
                    o_csr_we = 1'b1;
                    o_csr_waddr = CSR_MEPC;
                    o_csr_wdata = pc_q;
                end
                W_MCAUSE: begin
                    o_csr_we = 1'b1;
                    o_csr_waddr = CSR_MCAUSE;
                    o_csr_wdata = {irq_q, 27'd0, cause_q};
                end
                W_MTVAL: begin
                    o_csr_we = 1'b1;
                    o_csr_waddr = CSR_MTVAL;
                    o_csr_wdata = tval_q;
                end
                W_MSTATUS: begin
                    o_csr_we = 1'b1;
                    o_csr_waddr = CSR_MSTATUS;
                    o_csr_wdata = trap_mstatus(i_mstatus);
                end
                RET_MSTATUS: begin
                    o_csr_we = 1'b1;
                    o_csr_waddr = CSR_MSTATUS;
                    o_csr_wdata = ret_mstatus(i_mstatus);
                end
                TRAP_REDIR: o_go_to_trap_q = 1'b1;
                RET_REDIR: o_return_from_trap_q = 1'b1;
                default: o_csr_we = 1'b0;
            endcase
        end
    end

    // vectored mode offsets only interrupts, by 4 bytes per cause
    assign o_trap_address = {i_mtvec[31:2], 2'b00} + ((i_mtvec[1:0] == 2'b01 && irq_q) ? {26'd0, cause_q, 2'b00} : 32'd0);
    assign o_return_address = i_mepc;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed vectors for trap entry, mret, overrides, stall and reset
module tb_trap_sequencer;
    logic i_clk = 1'b0, i_rst = 1'b1;
    logic i_external_interrupt = 0, i_software_interrupt = 0, i_timer_interrupt = 0;
    logic [31:0] i_mie = 0, i_mstatus = 0, i_mtvec = 0, i_mepc = 0, i_pc = 0, i_y = 0;
    logic i_is_inst_illegal = 0, i_is_ebreak = 0, i_is_ecall = 0, i_load_misaligned = 0, i_store_misaligned = 0;
    logic i_is_mret = 0, i_stall = 0, writeback_change_pc = 0;
    logic o_csr_we, o_go_to_trap_q, o_return_from_trap_q, o_busy;
    logic [11:0] o_csr_waddr;
    logic [31:0] o_csr_wdata, o_trap_address, o_return_address;
    int vectors = 0, miscompares = 0;

    trap_sequencer dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_external_interrupt(i_external_interrupt), .i_software_interrupt(i_software_interrupt),
        .i_timer_interrupt(i_timer_interrupt), .i_mie(i_mie), .i_mstatus(i_mstatus),
        .i_mtvec(i_mtvec), .i_mepc(i_mepc), .i_is_inst_illegal(i_is_inst_illegal),
        .i_is_ebreak(i_is_ebreak), .i_is_ecall(i_is_ecall), .i_load_misaligned(i_load_misaligned),
        .i_store_misaligned(i_store_misaligned), .i_is_mret(i_is_mret), .i_pc(i_pc), .i_y(i_y),
        .i_stall(i_stall), .writeback_change_pc(writeback_change_pc),
        .o_csr_we(o_csr_we), .o_csr_waddr(o_csr_waddr), .o_csr_wdata(o_csr_wdata),
        .o_trap_address(o_trap_address), .o_return_address(o_return_address),
        .o_go_to_trap_q(o_go_to_trap_q), .o_return_from_trap_q(o_return_from_trap_q), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic csr(input string tag, input logic [11:0] addr, input logic [31:0] data);
        #1;
        chk({tag, "_we"}, {31'd0, o_csr_we}, 32'd1);
        chk({tag, "_addr"}, {20'd0, o_csr_waddr}, {20'd0, addr});
        chk({tag, "_data"}, o_csr_wdata, data);
    endtask

    task automatic quiet(input string tag, input logic busy);
        #1;
        chk({tag, "_we"}, {31'd0, o_csr_we}, 32'd0);
        chk({tag, "_addr"}, {20'd0, o_csr_waddr}, 32'd0);
        chk({tag, "_data"}, o_csr_wdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_busy}, {31'd0, busy});
    endtask

    initial begin
        cyc();
        cyc();
        quiet("reset", 1'b0);
        chk("reset_go", {31'd0, o_go_to_trap_q}, 32'd0);
        chk("reset_ret", {31'd0, o_return_from_trap_q}, 32'd0);
        i_rst = 0;
        cyc();
        // ecall at pc 0x100, direct mtvec
        i_pc = 32'h100; i_mtvec = 32'h200; i_mstatus = 32'h8; i_is_ecall = 1;
        quiet("ecall_n", 1'b0);
        cyc(); i_is_ecall = 0;
        csr("ecall_mepc", 12'h341, 32'h100);
        cyc(); csr("ecall_mcause", 12'h342, 32'd11);
        cyc(); csr("ecall_mtval", 12'h343, 32'd0);
        cyc(); csr("ecall_mstatus", 12'h300, 32'h1880);
        cyc(); quiet("ecall_redir", 1'b1);
        chk("ecall_go", {31'd0, o_go_to_trap_q}, 32'd1);
        chk("ecall_addr", o_trap_address, 32'h200);
        cyc(); quiet("ecall_done", 1'b0);
        chk("ecall_go_end", {31'd0, o_go_to_trap_q}, 32'd0);
        // masked interrupts are not taken
        i_mie = 32'h800; i_timer_interrupt = 1;
        cyc(); quiet("tmr_masked", 1'b0);
        i_timer_interrupt = 0; i_external_interrupt = 1; i_mstatus = 0;
        cyc(); quiet("ext_gie_off", 1'b0);
        // external irq beats illegal, vectored mtvec; mret while busy is dropped
        i_mstatus = 32'h8; i_mtvec = 32'h201; i_is_inst_illegal = 1; i_pc = 32'h400;
        cyc(); i_external_interrupt = 0; i_is_inst_illegal = 0;
        csr("irq_mepc", 12'h341, 32'h400);
        cyc(); csr("irq_mcause", 12'h342, 32'h8000000B);
        cyc(); i_is_mret = 1; csr("irq_mtval", 12'h343, 32'd0);
        cyc(); csr("irq_mstatus", 12'h300, 32'h1880);
        cyc(); i_is_mret = 0; #1;
        chk("irq_go", {31'd0, o_go_to_trap_q}, 32'd1);
        chk("irq_addr", o_trap_address, 32'h22C);
        cyc(); quiet("irq_done", 1'b0);
        cyc(); quiet("mret_not_queued", 1'b0);
        // mret
        i_mepc = 32'h344; i_mstatus = 32'h80; i_is_mret = 1;
        cyc(); i_is_mret = 0;
        csr("mret_mstatus", 12'h300, 32'h1888);
        cyc(); quiet("mret_redir", 1'b1);
        chk("mret_pulse", {31'd0, o_return_from_trap_q}, 32'd1);
        chk("mret_addr", o_return_address, 32'h344);
        cyc(); quiet("mret_done", 1'b0);
        // load misaligned blocked by writeback redirect, then taken over a simultaneous mret
        i_mstatus = 0; i_pc = 32'h500; i_y = 32'h1003; i_load_misaligned = 1; i_is_mret = 1; writeback_change_pc = 1;
        cyc(); quiet("wb_block", 1'b0);
        writeback_change_pc = 0;
        cyc(); i_load_misaligned = 0; i_is_mret = 0;
        csr("lmis_mepc", 12'h341, 32'h500);
        cyc(); csr("lmis_mcause", 12'h342, 32'd4);
        cyc(); csr("lmis_mtval", 12'h343, 32'h1003);
        cyc(); csr("lmis_mstatus", 12'h300, 32'h1800);
        cyc(); #1;
        chk("lmis_go", {31'd0, o_go_to_trap_q}, 32'd1);
        chk("lmis_addr", o_trap_address, 32'h200);
        cyc();
        // stall three cycles in W_MCAUSE
        i_pc = 32'h600; i_mtvec = 32'h300; i_is_ecall = 1;
        cyc(); i_is_ecall = 0;
        csr("stall_mepc", 12'h341, 32'h600);
        cyc(); i_stall = 1; quiet("stall_1", 1'b1);
        chk("stall_go_1", {31'd0, o_go_to_trap_q}, 32'd0);
        cyc(); quiet("stall_2", 1'b1);
        cyc(); quiet("stall_3", 1'b1);
        cyc(); i_stall = 0; csr("stall_mcause", 12'h342, 32'd11);
        cyc(); csr("stall_mtval", 12'h343, 32'd0);
        cyc(); csr("stall_mstatus", 12'h300, 32'h1800);
        cyc(); #1;
        chk("stall_go", {31'd0, o_go_to_trap_q}, 32'd1);
        chk("stall_addr", o_trap_address, 32'h300);
        cyc();
        // reset during W_MTVAL
        i_pc = 32'h700; i_is_ecall = 1;
        cyc(); i_is_ecall = 0;
        cyc();
        cyc(); i_rst = 1; quiet("rst_mtval", 1'b0);
        cyc(); i_rst = 0;
        for (int k = 0; k < 6; k++) begin
            quiet("rst_after", 1'b0);
            chk("rst_after_go", {31'd0, o_go_to_trap_q}, 32'd0);
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
